// File: rtl/sys_ctrl_pkg.sv
// Shared types and constants for the system-control to UART TX path.
package sys_ctrl_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 8;
  localparam int unsigned BCNT_W         = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_SEND = 2'd2,
    ST_HOLD = 2'd3
  } tx_state_e;

endpackage

// File: rtl/sys_tx_ctrl_if.sv
// Request and TX-handshake bundle between system control, sys_tx_ctrl and the UART TX FSM.
interface sys_tx_ctrl_if
  import sys_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
);

  logic [2*DATA_WIDTH-1:0] alu_out_in;
  logic                    alu_valid_in;
  logic [DATA_WIDTH-1:0]   rd_data_in;
  logic                    rd_valid_in;
  logic                    tx_busy_in;
  logic [DATA_WIDTH-1:0]   tx_data_out;
  logic                    tx_valid_out;
  logic                    ready_out;
  logic                    drop_out;

  modport slave (
    input  alu_out_in,
    input  alu_valid_in,
    input  rd_data_in,
    input  rd_valid_in,
    input  tx_busy_in,
    output tx_data_out,
    output tx_valid_out,
    output ready_out,
    output drop_out
  );

  modport master (
    output alu_out_in,
    output alu_valid_in,
    output rd_data_in,
    output rd_valid_in,
    output tx_busy_in,
    input  tx_data_out,
    input  tx_valid_out,
    input  ready_out,
    input  drop_out
  );

endinterface

// File: rtl/sys_tx_ctrl.sv
// Frame sequencer: sends an ALU result (low byte, then high) or a register read
// as bytes to the UART TX FSM, pacing each byte off the registered TX busy flag.
module sys_tx_ctrl
  import sys_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) (
  input logic          clk,
  input logic          reset,
  sys_tx_ctrl_if.slave bus
);

  tx_state_e               state_q,      state_d;
  logic [2*DATA_WIDTH-1:0] hold_q,       hold_d;
  logic [BCNT_W-1:0]       bytes_left_q, bytes_left_d;
  logic [DATA_WIDTH-1:0]   tx_data_q,    tx_data_d;
  logic                    drop_q,       drop_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      hold_q       <= '0;
      bytes_left_q <= '0;
      tx_data_q    <= '0;
      drop_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      bytes_left_q <= bytes_left_d;
      tx_data_q    <= tx_data_d;
      drop_q       <= drop_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (bus.alu_valid_in || bus.rd_valid_in) state_d = ST_ARM;
      // Busy must be low first so a frame still in flight is not taken as the ack.
      ST_ARM:  if (!bus.tx_busy_in) state_d = ST_SEND;
      ST_SEND: if (bus.tx_busy_in)  state_d = ST_HOLD;
      ST_HOLD: begin
        if (!bus.tx_busy_in) begin
          state_d = (bytes_left_q != '0) ? ST_SEND : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    hold_d       = hold_q;
    bytes_left_d = bytes_left_q;
    tx_data_d    = tx_data_q;
    drop_d       = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.alu_valid_in) begin
          hold_d       = bus.alu_out_in;
          bytes_left_d = BCNT_W'(2);
        end else if (bus.rd_valid_in) begin
          hold_d       = {{DATA_WIDTH{1'b0}}, bus.rd_data_in};
          bytes_left_d = BCNT_W'(1);
        end
        drop_d = bus.alu_valid_in && bus.rd_valid_in;
      end
      ST_ARM: begin
        if (!bus.tx_busy_in) tx_data_d = hold_q[DATA_WIDTH-1:0];
      end
      ST_SEND: begin
        if (bus.tx_busy_in && (bytes_left_q != '0)) begin
          bytes_left_d = bytes_left_q - BCNT_W'(1);
        end
      end
      ST_HOLD: begin
        // ARM only ever follows IDLE, so any byte loaded from HOLD is the high byte.
        if (!bus.tx_busy_in && (bytes_left_q != '0)) begin
          tx_data_d = hold_q[2*DATA_WIDTH-1:DATA_WIDTH];
        end
      end
      default: ;
    endcase
    if (state_q != ST_IDLE) drop_d = bus.alu_valid_in || bus.rd_valid_in;
  end

  always_comb begin
    bus.ready_out    = (state_q == ST_IDLE);
    bus.tx_valid_out = (state_q == ST_SEND);
    bus.tx_data_out  = tx_data_q;
    bus.drop_out     = drop_q;
  end

endmodule

// File: doc/sys_tx_ctrl.md
# sys_tx_ctrl

Upstream frame sequencer for the UART transmit path. Accepts a 16-bit ALU result or an 8-bit register-file read and delivers it as one or two bytes to the UART TX controller. Per byte, it drives `tx_valid_out` and `tx_data_out` and paces itself off the TX block's `busy` output. Sits between the system control logic (ALU / register file) and the UART TX FSM plus serializer, in the same clock domain as the TX path.

## Interface
- `DATA_WIDTH`, default 8: UART byte width; the ALU result is 2*DATA_WIDTH.
- `clk`  in  1: single clock; all logic on posedge.
- `reset`  in  1: synchronous, active-high; clears all state on the clock edge where it is sampled high.
- `alu_out_in`  in  2*DATA_WIDTH: ALU result; sent low byte first, then high byte.
- `alu_valid_in`  in  1: one-cycle request qualifying `alu_out_in`.
- `rd_data_in`  in  DATA_WIDTH: register-file read data; sent as a single byte.
- `rd_valid_in`  in  1: one-cycle request qualifying `rd_data_in`.
- `tx_busy_in`  in  1: UART TX busy (registered, rises one cycle after the TX FSM leaves IDLE).
- `tx_data_out`  out  DATA_WIDTH: byte presented to the TX serializer; registered.
- `tx_valid_out`  out  1: byte request to the TX FSM (`data_valid_in` there).
- `ready_out`  out  1: block can accept a request this cycle.
- `drop_out`  out  1: one-cycle pulse when a request is discarded.

## Operation
- States: IDLE, ARM, SEND, HOLD. `ready_out` = (state == IDLE). `tx_valid_out` = (state == SEND).
- IDLE: on `alu_valid_in`, capture `alu_out_in` into the 16-bit holding register and set `bytes_left` = 2. Otherwise on `rd_valid_in`, capture into the low byte and set `bytes_left` = 1. Either capture moves to ARM.
- ARM: wait for `tx_busy_in` = 0, so a frame already in flight is never mistaken for an acknowledge. Then load `tx_data_out` with the current byte (low byte first) and go to SEND.
- SEND: hold `tx_valid_out` = 1 with `tx_data_out` stable until `tx_busy_in` = 1, then go to HOLD and decrement `bytes_left`.
- HOLD: `tx_valid_out` = 0 and `tx_data_out` held until `tx_busy_in` = 0.
  - If `bytes_left` != 0: load the high byte and go to SEND.
  - Otherwise go to IDLE.
  - Dropping valid in HOLD makes the TX FSM return from STOP to IDLE, so busy falls once per byte.
- Simultaneous `alu_valid_in` and `rd_valid_in` in IDLE: the ALU request is taken, the read is discarded, and `drop_out` pulses.
- Any valid while not in IDLE: the request is discarded, `drop_out` pulses, and the transfer in progress is unaffected.
- `bytes_left` is 2 bits, and the decrement saturates at 0.

## Timing
- Reset values: state IDLE, `tx_valid_out` 0, `tx_data_out` 0, `drop_out` 0, holding register 0, `bytes_left` 0. `ready_out` reads 1 after the reset edge.
- Request accepted at edge N, with busy low:
  - state ARM during cycle N+1;
  - SEND and `tx_valid_out` = 1 from cycle N+2.
- `tx_valid_out` stays high at least 2 cycles, until the TX FSM has gone IDLE to START and busy has registered high.
- The high byte's SEND starts the cycle after busy falls in HOLD. There are no idle bubbles beyond the busy handshake.
- `drop_out` is registered: it asserts the cycle after the offending valid, for exactly 1 cycle.
- Reset asserted mid-transfer (any state): at the next edge all outputs take their reset values and the partial frame is abandoned. `tx_valid_out` low ensures the TX FSM finishes its current byte and then idles.
- `tx_busy_in` stuck high: the block waits indefinitely in ARM/HOLD. No timeout.

## Structure
- Shared package `sys_ctrl_pkg` holds:
  - the state enum type (IDLE/ARM/SEND/HOLD);
  - the `DATA_WIDTH` default constant;
  - the byte-count width constant.
- Single module, no sub-module. Contents: one FSM with a state register and combinational next-state logic, the holding register, and the `bytes_left` counter.

## Test plan
- Reset, then `alu_valid_in` with `alu_out_in` = 16'hA55A, using a TX FSM model (busy rises 2 cycles after valid, 11-cycle frame) -> `tx_data_out` 8'h5A then 8'hA5, exactly two `tx_valid_out` bursts, `ready_out` back to 1 after the second busy fall.
- `rd_valid_in` with `rd_data_in` = 8'h3C -> one byte, 8'h3C, `tx_valid_out` high from cycle N+2 until busy rises, then IDLE.
- `alu_valid_in` and `rd_valid_in` in the same cycle (16'h1234, 8'hFF) -> bytes 8'h34, 8'h12 sent, `drop_out` pulses once, 8'hFF never appears.
- `rd_valid_in` while in HOLD of an ALU transfer -> `drop_out` pulse, ALU bytes unaffected.
- `tx_busy_in` held high when a request arrives -> state stays ARM and `tx_valid_out` stays 0 until busy falls, then SEND.
- Reset asserted in SEND of the high byte -> next cycle `tx_valid_out` = 0, `tx_data_out` = 0, `ready_out` = 1, and no further bytes.
